// File: rtl/if_id_skid_stage.sv
// rtl/if_id_skid_stage.sv - IF/ID pipeline register with two-entry skid buffer and field decode
module if_id_skid_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000,
  parameter logic [31:0] RESET_PC  = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_instr,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc4,
  output logic [31:0] out_instr,
  output logic [5:0]  out_opcode,
  output logic [4:0]  out_rs,
  output logic [4:0]  out_rt,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_shamt,
  output logic [5:0]  out_funct,
  output logic [15:0] out_imm16
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
  typedef enum logic [1:0] {MAIN_HOLD, MAIN_IN, MAIN_SKID, MAIN_NOP} main_sel_t;

  state_t      state, next_state;
  main_sel_t   main_sel;
  logic        skid_load;
  logic        ready_q;
  logic        in_xfer, out_xfer;
  logic [31:0] main_pc, main_instr, skid_pc, skid_instr;

  assign in_xfer  = in_valid && ready_q;
  assign out_xfer = (state != EMPTY) && out_ready;

  always_comb begin
    next_state = state;
    main_sel   = MAIN_HOLD;
    skid_load  = 1'b0;
    if (flush) begin
      next_state = EMPTY;
      main_sel   = MAIN_NOP;
    end else begin
      case (state)
        EMPTY: if (in_xfer) begin
          next_state = ONE;
          main_sel   = MAIN_IN;
        end
        ONE: begin
          if (in_xfer && out_xfer) begin
            main_sel = MAIN_IN;
          end else if (in_xfer) begin
            next_state = TWO;
            skid_load  = 1'b1;
          end else if (out_xfer) begin
            next_state = EMPTY;
            main_sel   = MAIN_NOP;
          end
        end
        TWO: if (out_xfer) begin
          next_state = ONE;
          main_sel   = MAIN_SKID;
        end
        default: begin
          next_state = EMPTY;
          main_sel   = MAIN_NOP;
        end
      endcase
    end
  end

  // ready is registered from the next state so it never sees out_ready combinationally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= EMPTY;
      ready_q    <= 1'b1;
      main_pc    <= RESET_PC;
      main_instr <= NOP_INSTR;
      skid_pc    <= RESET_PC;
      skid_instr <= NOP_INSTR;
    end else begin
      state   <= next_state;
      ready_q <= (next_state != TWO);
      case (main_sel)
        MAIN_IN: begin
          main_pc    <= in_pc;
          main_instr <= in_instr;
        end
        MAIN_SKID: begin
          main_pc    <= skid_pc;
          main_instr <= skid_instr;
        end
        MAIN_NOP: begin
          main_pc    <= RESET_PC;
          main_instr <= NOP_INSTR;
        end
        default: begin
          main_pc    <= main_pc;
          main_instr <= main_instr;
        end
      endcase
      if (skid_load) begin
        skid_pc    <= in_pc;
        skid_instr <= in_instr;
      end
    end
  end

  assign in_ready   = ready_q;
  assign out_valid  = (state != EMPTY);
  assign out_pc     = main_pc;
  assign out_pc4    = main_pc + 32'd4;
  assign out_instr  = main_instr;
  assign out_opcode = main_instr[31:26];
  assign out_rs     = main_instr[25:21];
  assign out_rt     = main_instr[20:16];
  assign out_rd     = main_instr[15:11];
  assign out_shamt  = main_instr[10:6];
  assign out_funct  = main_instr[5:0];
  assign out_imm16  = main_instr[15:0];

endmodule
